// File: rtl/usb_fifo_pkg.sv
// Shared constants and elaboration helpers for the USB endpoint FIFOs.
package usb_fifo_pkg;

  localparam int USB_EP_FIFO_DEPTH = 256;
  localparam int USB_EP_FIFO_WIDTH = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/usb_fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, asynchronous read, no reset.
module usb_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_pkt_fifo.sv
// Packet FIFO with commit/rollback: writes stay tentative until committed,
// and the read side only ever sees committed words.
module usb_pkt_fifo
  import usb_fifo_pkg::*;
#(
  parameter int WIDTH    = USB_EP_FIFO_WIDTH,
  parameter int DEPTH    = USB_EP_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 8,
  parameter int AE_LEVEL = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   w_en,
  input  logic                   w_commit,
  input  logic                   w_drop,
  output logic                   full,
  output logic                   overflow,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PW     = ADDR_W + 1;

  localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LEVEL_P = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LEVEL_P = PW'(AE_LEVEL);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("usb_pkt_fifo: DEPTH must be a power of two and at least 4");
    end
  endgenerate

  logic [PW-1:0] r_wPtr;
  logic [PW-1:0] r_cPtr;
  logic [PW-1:0] r_rPtr;
  logic          r_pktErr;
  logic          r_overflow;
  logic          r_underflow;

  logic [PW-1:0] w_used;
  logic [PW-1:0] w_count;
  logic          w_wrAccept;
  logic          w_rdAccept;
  logic          w_rollback;
  logic [PW-1:0] w_wPtrNext;

  // The wrap bit makes used == DEPTH distinguishable from used == 0.
  assign w_used     = r_wPtr - r_rPtr;
  assign w_count    = r_cPtr - r_rPtr;
  assign full       = (w_used == DEPTH_P);
  assign empty      = (w_count == '0);
  assign w_wrAccept = w_en && !full;
  assign w_rdAccept = r_en && !empty;
  assign w_rollback = w_drop || (w_commit && r_pktErr);
  assign w_wPtrNext = w_wrAccept ? (r_wPtr + PW'(1)) : r_wPtr;

  assign count        = w_count;
  assign almost_full  = (w_used >= AF_LEVEL_P);
  assign almost_empty = (w_count <= AE_LEVEL_P);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A packet that lost a word to overflow is unusable, so its commit rolls back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wPtr      <= '0;
      r_cPtr      <= '0;
      r_rPtr      <= '0;
      r_pktErr    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_rollback) begin
        r_wPtr   <= r_cPtr;
        r_pktErr <= 1'b0;
      end else if (w_commit) begin
        r_wPtr   <= w_wPtrNext;
        r_cPtr   <= w_wPtrNext;
        r_pktErr <= 1'b0;
      end else begin
        r_wPtr <= w_wPtrNext;
        if (w_en && full) begin
          r_pktErr <= 1'b1;
        end
      end

      if (w_rdAccept) begin
        r_rPtr <= r_rPtr + PW'(1);
      end

      r_overflow  <= w_en && full;
      r_underflow <= r_en && empty;
    end
  end

  usb_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wrAccept),
    .i_waddr (r_wPtr[ADDR_W-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rPtr[ADDR_W-1:0]),
    .o_rdata (data_out)
  );

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// Directed bench for usb_pkt_fifo at DEPTH=16 covering commit, drop, overflow and wrap.
module tb_usb_pkt_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn;
  logic       wEn;
  logic       wCommit;
  logic       wDrop;
  logic       full;
  logic       overflow;
  logic       rEn;
  logic [7:0] dataOut;
  logic       empty;
  logic       underflow;
  logic [4:0] count;
  logic       almostFull;
  logic       almostEmpty;

  int passCount  = 0;
  int checkCount = 0;

  usb_pkt_fifo #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (dataIn),
    .w_en         (wEn),
    .w_commit     (wCommit),
    .w_drop       (wDrop),
    .full         (full),
    .overflow     (overflow),
    .r_en         (rEn),
    .data_out     (dataOut),
    .empty        (empty),
    .underflow    (underflow),
    .count        (count),
    .almost_full  (almostFull),
    .almost_empty (almostEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed one falling edge later.
  task automatic doCycle(input logic we, input logic [7:0] d, input logic cm,
                         input logic dr, input logic re);
    wEn     = we;
    dataIn  = d;
    wCommit = cm;
    wDrop   = dr;
    rEn     = re;
    @(negedge clk);
    wEn     = 1'b0;
    dataIn  = 8'h00;
    wCommit = 1'b0;
    wDrop   = 1'b0;
    rEn     = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty); else passCount++;
    checkCount++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b want 0", full); else passCount++;
    checkCount++; if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passCount++;
    checkCount++; if (almostEmpty !== 1'b1) $display("[TB] FAIL reset_ae: got %b want 1", almostEmpty); else passCount++;
    checkCount++; if (almostFull !== 1'b0) $display("[TB] FAIL reset_af: got %b want 0", almostFull); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", overflow); else passCount++;
    checkCount++; if (underflow !== 1'b0) $display("[TB] FAIL reset_udf: got %b want 0", underflow); else passCount++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_commit();
    logic [7:0] expData [3];
    expData = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) doCycle(1'b1, expData[i], 1'b0, 1'b0, 1'b0);
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL tentative_empty: got %b want 1", empty); else passCount++;
    checkCount++; if (count !== 5'd0) $display("[TB] FAIL tentative_count: got %0d want 0", count); else passCount++;
    doCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount++; if (empty !== 1'b0) $display("[TB] FAIL commit_empty: got %b want 0", empty); else passCount++;
    checkCount++; if (count !== 5'd3) $display("[TB] FAIL commit_count: got %0d want 3", count); else passCount++;
    checkCount++; if (almostEmpty !== 1'b1) $display("[TB] FAIL commit_ae: got %b want 1", almostEmpty); else passCount++;
    for (int i = 0; i < 3; i++) begin
      checkCount++; if (dataOut !== expData[i]) $display("[TB] FAIL commit_read%0d: got %h want %h", i, dataOut, expData[i]); else passCount++;
      doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL commit_drained: got %b want 1", empty); else passCount++;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 8; i++) doCycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    checkCount++; if (almostFull !== 1'b1) $display("[TB] FAIL drop_af_before: got %b want 1", almostFull); else passCount++;
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL drop_empty_before: got %b want 1", empty); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkCount++; if (almostFull !== 1'b0) $display("[TB] FAIL drop_af_after: got %b want 0", almostFull); else passCount++;
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL drop_empty_after: got %b want 1", empty); else passCount++;
    doCycle(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd2) $display("[TB] FAIL drop_next_count: got %0d want 2", count); else passCount++;
    checkCount++; if (dataOut !== 8'hB0) $display("[TB] FAIL drop_next_head: got %h want b0", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (dataOut !== 8'hB1) $display("[TB] FAIL drop_next_second: got %h want b1", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL drop_drained: got %b want 1", empty); else passCount++;
  endtask

  task automatic test_overflow();
    logic [7:0] expByte;
    for (int i = 0; i < 16; i++) doCycle(1'b1, 8'(8'h40 + i), (i == 15), 1'b0, 1'b0);
    checkCount++; if (full !== 1'b1) $display("[TB] FAIL fill_full: got %b want 1", full); else passCount++;
    checkCount++; if (count !== 5'd16) $display("[TB] FAIL fill_count: got %0d want 16", count); else passCount++;
    checkCount++; if (almostFull !== 1'b1) $display("[TB] FAIL fill_af: got %b want 1", almostFull); else passCount++;
    checkCount++; if (almostEmpty !== 1'b0) $display("[TB] FAIL fill_ae: got %b want 0", almostEmpty); else passCount++;
    checkCount++; if (dataOut !== 8'h40) $display("[TB] FAIL fill_head: got %h want 40", dataOut); else passCount++;
    doCycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_pulse: got %b want 1", overflow); else passCount++;
    checkCount++; if (count !== 5'd16) $display("[TB] FAIL ovf_count: got %0d want 16", count); else passCount++;
    doCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_pulse_end: got %b want 0", overflow); else passCount++;
    checkCount++; if (count !== 5'd16) $display("[TB] FAIL ovf_commit_count: got %0d want 16", count); else passCount++;
    doCycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    checkCount++; if (count !== 5'd15) $display("[TB] FAIL rdwr_full_count: got %0d want 15", count); else passCount++;
    checkCount++; if (full !== 1'b0) $display("[TB] FAIL rdwr_full_flag: got %b want 0", full); else passCount++;
    checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL rdwr_full_ovf: got %b want 1", overflow); else passCount++;
    checkCount++; if (dataOut !== 8'h41) $display("[TB] FAIL rdwr_full_head: got %h want 41", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd15) $display("[TB] FAIL err_commit_count: got %0d want 15", count); else passCount++;
    doCycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd16) $display("[TB] FAIL refill_count: got %0d want 16", count); else passCount++;
    checkCount++; if (full !== 1'b1) $display("[TB] FAIL refill_full: got %b want 1", full); else passCount++;
    for (int i = 0; i < 16; i++) begin
      expByte = (i < 15) ? 8'(8'h41 + i) : 8'h77;
      checkCount++; if (dataOut !== expByte) $display("[TB] FAIL ovf_drain%0d: got %h want %h", i, dataOut, expByte); else passCount++;
      doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL ovf_drained: got %b want 1", empty); else passCount++;
  endtask

  task automatic test_same_cycle();
    doCycle(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd1) $display("[TB] FAIL wr_commit_count: got %0d want 1", count); else passCount++;
    checkCount++; if (dataOut !== 8'h5C) $display("[TB] FAIL wr_commit_head: got %h want 5c", dataOut); else passCount++;
    doCycle(1'b1, 8'h5D, 1'b1, 1'b1, 1'b0);
    checkCount++; if (count !== 5'd1) $display("[TB] FAIL commit_drop_count: got %0d want 1", count); else passCount++;
    doCycle(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkCount++; if (count !== 5'd1) $display("[TB] FAIL drop_wins_count: got %0d want 1", count); else passCount++;
    doCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd1) $display("[TB] FAIL noop_commit_count: got %0d want 1", count); else passCount++;
    doCycle(1'b1, 8'h5E, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd2) $display("[TB] FAIL late_commit_count: got %0d want 2", count); else passCount++;
    checkCount++; if (dataOut !== 8'h5C) $display("[TB] FAIL same_head0: got %h want 5c", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (dataOut !== 8'h5E) $display("[TB] FAIL same_head1: got %h want 5e", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL same_drained: got %b want 1", empty); else passCount++;
  endtask

  task automatic test_wrap();
    logic [7:0] expByte;
    for (int i = 0; i < 40; i++) begin
      expByte = 8'(8'hC0 + i);
      doCycle(1'b1, expByte, 1'b1, 1'b0, 1'b0);
      checkCount++; if (count !== 5'd1) $display("[TB] FAIL wrap_count%0d: got %0d want 1", i, count); else passCount++;
      checkCount++; if (empty !== 1'b0) $display("[TB] FAIL wrap_empty%0d: got %b want 0", i, empty); else passCount++;
      checkCount++; if (dataOut !== expByte) $display("[TB] FAIL wrap_data%0d: got %h want %h", i, dataOut, expByte); else passCount++;
      doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkCount++; if (empty !== 1'b1) $display("[TB] FAIL wrap_popped%0d: got %b want 1", i, empty); else passCount++;
      checkCount++; if (full !== 1'b0) $display("[TB] FAIL wrap_full%0d: got %b want 0", i, full); else passCount++;
    end
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (underflow !== 1'b1) $display("[TB] FAIL udf_pulse: got %b want 1", underflow); else passCount++;
    checkCount++; if (count !== 5'd0) $display("[TB] FAIL udf_count: got %0d want 0", count); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkCount++; if (underflow !== 1'b0) $display("[TB] FAIL udf_pulse_end: got %b want 0", underflow); else passCount++;
    doCycle(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    checkCount++; if (dataOut !== 8'hD1) $display("[TB] FAIL udf_next_head: got %h want d1", dataOut); else passCount++;
    checkCount++; if (count !== 5'd1) $display("[TB] FAIL udf_next_count: got %0d want 1", count); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) doCycle(1'b1, 8'(8'hE0 + i), (i == 3), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) doCycle(1'b1, 8'(8'hA8 + i), 1'b0, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd4) $display("[TB] FAIL prereset_count: got %0d want 4", count); else passCount++;
    #2 rst = 1'b0;
    #1;
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL arst_empty: got %b want 1", empty); else passCount++;
    checkCount++; if (count !== 5'd0) $display("[TB] FAIL arst_count: got %0d want 0", count); else passCount++;
    checkCount++; if (full !== 1'b0) $display("[TB] FAIL arst_full: got %b want 0", full); else passCount++;
    checkCount++; if (almostFull !== 1'b0) $display("[TB] FAIL arst_af: got %b want 0", almostFull); else passCount++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    doCycle(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 8'hF1, 1'b1, 1'b0, 1'b0);
    checkCount++; if (count !== 5'd2) $display("[TB] FAIL postrst_count: got %0d want 2", count); else passCount++;
    checkCount++; if (dataOut !== 8'hF0) $display("[TB] FAIL postrst_head: got %h want f0", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (dataOut !== 8'hF1) $display("[TB] FAIL postrst_second: got %h want f1", dataOut); else passCount++;
    doCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkCount++; if (empty !== 1'b1) $display("[TB] FAIL postrst_drained: got %b want 1", empty); else passCount++;
  endtask

  initial begin
    rst     = 1'b0;
    dataIn  = 8'h00;
    wEn     = 1'b0;
    wCommit = 1'b0;
    wDrop   = 1'b0;
    rEn     = 1'b0;
    $display("[TB] starting usb_pkt_fifo bench");
    test_reset();
    test_commit();
    test_drop();
    test_overflow();
    test_same_cycle();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
